// File: rtl/exec_int.sv
// exec_int: single-cycle integer execute unit with an in-order result buffer.
//
// An op is accepted from the issue stage, its result is computed
// combinationally in the accept cycle, and the result is queued in a
// DEPTH-entry FIFO. The head entry is offered on the common data bus
// until the arbiter grants it.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   issue_en            - issue stage offers an op this cycle
//   issue_opcode/rdtag  - operation select and destination tag
//   issue_rsdata/rtdata - operands A and B
//   issue_ready         - buffer has room (registered count only)
//   cdb_req             - a result is waiting at the head
//   cdb_data/tag        - head result payload (zero when empty)
//   cdb_branch/taken    - head branch flags (zero when empty)
//   cdb_grant           - arbiter takes the head result this cycle
//
// Handshakes: a transfer happens on a rising edge where the sender's
// valid (issue_en / cdb_req) and the receiver's ready (issue_ready /
// cdb_grant) are both high; valid with ready low is ignored and changes
// nothing, and ready never depends combinationally on the other side.
module exec_int #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_en,
    input  logic [2:0]  issue_opcode,
    input  logic [5:0]  issue_rdtag,
    input  logic [31:0] issue_rsdata,
    input  logic [31:0] issue_rtdata,
    output logic        issue_ready,
    output logic        cdb_req,
    output logic [31:0] cdb_data,
    output logic [5:0]  cdb_tag,
    output logic        cdb_branch,
    output logic        cdb_branch_taken,
    input  logic        cdb_grant
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0] data;
        logic [5:0]  tag;
        logic        branch;
        logic        taken;
    } entry_t;

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    entry_t           buf_q [DEPTH];
    entry_t           new_entry;
    entry_t           head;
    logic             push;
    logic             pop;

    // Result computation for the op being presented this cycle.
    always_comb begin
        new_entry        = '0;
        new_entry.tag    = issue_rdtag;
        case (issue_opcode)
            3'b000: new_entry.data = issue_rsdata + issue_rtdata;
            3'b001: new_entry.data = issue_rsdata - issue_rtdata;
            3'b010: new_entry.data = issue_rsdata & issue_rtdata;
            3'b011: new_entry.data = issue_rsdata | issue_rtdata;
            3'b100: new_entry.data = {31'd0, $signed(issue_rsdata) < $signed(issue_rtdata)};
            3'b101: begin
                new_entry.branch = 1'b1;
                new_entry.taken  = (issue_rsdata == issue_rtdata);
            end
            3'b110: begin
                new_entry.branch = 1'b1;
                new_entry.taken  = (issue_rsdata != issue_rtdata);
            end
            default: new_entry.data = issue_rsdata << issue_rtdata[4:0];
        endcase
    end

    assign issue_ready = (count_q < DEPTH_C);
    assign cdb_req     = (count_q != '0);
    assign push        = issue_en && issue_ready;
    assign pop         = cdb_req && cdb_grant;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Push and pop together leave the occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            buf_q[wr_ptr_q] <= new_entry;
        end
    end

    // Head outputs are zeroed when empty so stale payload never leaks.
    always_comb begin
        head = '0;
        if (cdb_req) begin
            head = buf_q[rd_ptr_q];
        end
    end

    assign cdb_data         = head.data;
    assign cdb_tag          = head.tag;
    assign cdb_branch       = head.branch;
    assign cdb_branch_taken = head.taken;

endmodule

// File: doc/exec_int.md
EXEC_INT -- requirements
Module: exec_int

Interface
REQ-001 Parameter: DEPTH, 2, number of entries in the result buffer (a power of two, at least 2).
REQ-002 Port: clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 Port: reset, input, 1, synchronous active-high reset.
REQ-004 Port: issue_en, input, 1, the issue stage presents a ready-to-execute op this cycle.
REQ-005 Port: issue_opcode, input, 3, operation select (see REQ-012).
REQ-006 Port: issue_rdtag, input, 6, destination tag to broadcast with the result.
REQ-007 Port: issue_rsdata, input, 32, operand A.
REQ-008 Port: issue_rtdata, input, 32, operand B.
REQ-009 Port: issue_ready, output, 1, the unit can accept an op this cycle.
REQ-010 Ports, all outputs: cdb_req (1, a result is pending), cdb_data (32), cdb_tag (6), cdb_branch (1), cdb_branch_taken (1).
REQ-011 Port: cdb_grant, input, 1, the CDB arbiter accepts the head result this cycle.

Function
REQ-012 The opcode map SHALL be:
- 000 ADD: A+B, mod 2^32
- 001 SUB: A-B, mod 2^32
- 010 AND
- 011 OR
- 100 SLT: signed A<B gives 32'd1, otherwise 32'd0
- 101 BEQ
- 110 BNE
- 111 SLL: A shifted left by B[4:0]
REQ-013 BEQ and BNE SHALL produce data 32'd0, branch=1 and taken=(A==B) or (A!=B) respectively; all other ops SHALL produce branch=0 and taken=0.
REQ-014 The result SHALL be computed combinationally in the accept cycle and written into a FIFO result buffer of DEPTH entries, each holding {data, tag, branch, taken}.
REQ-015 Accept SHALL occur when issue_en && issue_ready; issue_en while not ready SHALL be ignored with no state change.
REQ-016 issue_ready SHALL equal (count < DEPTH), derived from registered count only, with no same-cycle bypass from cdb_grant.
REQ-017 cdb_req SHALL equal (count != 0); the cdb_* data outputs SHALL reflect the head entry and SHALL be forced to 0 when the buffer is empty.
REQ-018 Pop SHALL occur when cdb_req && cdb_grant; cdb_grant while empty SHALL be ignored.
REQ-019 Latency: an op accepted in cycle N SHALL appear at the head with cdb_req=1 in cycle N+1 if the buffer was empty.
REQ-020 Results SHALL leave in accept order.
REQ-021 Head outputs SHALL hold stable while cdb_req=1 and cdb_grant=0.
REQ-022 Simultaneous push and pop SHALL leave count unchanged, including when count==DEPTH is not the case because ready is low at full.
REQ-023 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits wide.
REQ-024 Count SHALL never exceed DEPTH or underflow below 0.

Reset
REQ-025 While reset=1 at a clock edge, count and both pointers SHALL go to 0; outputs SHALL then be cdb_req=0, cdb_data=0, cdb_tag=0, cdb_branch=0, cdb_branch_taken=0 and issue_ready=1.
REQ-026 Reset SHALL take priority over a simultaneous accept or pop; all in-flight results are discarded.
REQ-027 Buffer payload storage need not be reset.

Verification
REQ-028 ADD with A=0xFFFFFFFF, B=1, tag 5 -> next cycle: cdb_req=1, data=0, tag=5, branch=0.
REQ-029 SLT with A=0xFFFFFFFE, B=1 -> data=1; SLL with A=1, B=0x23 -> data=8.
REQ-030 BNE with A=3, B=3 -> branch=1, taken=0, data=0; BEQ with A=3, B=3 -> taken=1.
REQ-031 Three back-to-back issues with grant held low -> first two accepted, issue_ready=0 from the cycle after the second, the third is ignored; then grant each cycle -> tags pop in order and issue_ready returns to 1.
REQ-032 With count=1, issue and grant in the same cycle -> count stays 1 and the new tag is at head next cycle; 8 ops streamed with grant=1 verify pointer wrap.
REQ-033 Buffer full, then reset asserted together with issue_en and cdb_grant -> next cycle: cdb_req=0, issue_ready=1, all cdb outputs 0.
